// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read bus between the fetch unit (master) and the
// instruction memory (slave).
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_W = 7
);
    logic [ADDR_W-1:0] IMemAddr;
    logic              IMemRead;
    logic [15:0]       IMemData;
    logic              IMemValid;

    modport master (
        output IMemAddr,
        output IMemRead,
        input  IMemData,
        input  IMemValid
    );

    modport slave (
        input  IMemAddr,
        input  IMemRead,
        output IMemData,
        output IMemValid
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns PC and IR and runs the read handshake to
// instruction memory on behalf of the controller FSM.
// Optional feature macro: IFU_PREFETCH_EN (one-word prefetch buffer).
module instruction_fetch_unit #(
    parameter int unsigned       ADDR_W   = 7,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      PCClr,
    input  logic                      PCUp,
    input  logic                      IRLd,
    instruction_fetch_unit_if.master  imem,
    output logic [15:0]               Instruction,
    output logic [ADDR_W-1:0]         PCOut,
    output logic                      IRValid,
    output logic                      FetchStall
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT     = 2'd1;
`ifdef IFU_PREFETCH_EN
    localparam logic [1:0] S_PREFETCH = 2'd2;
`endif

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic              r_ir_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_read;
    logic [ADDR_W-1:0] w_pc_next;
`ifdef IFU_PREFETCH_EN
    logic [15:0]       r_pf_data;
    logic [ADDR_W-1:0] r_pf_tag;
    logic              r_pf_valid;
`endif

    // PC value after this edge when an accepted request carries PCUp
    always_comb begin
        w_pc_next = PCUp ? r_pc + ADDR_W'(1) : r_pc;
    end

    // PC / IR / memory handshake state machine; PCClr overrides every state
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_mem_read <= 1'b0;
`ifdef IFU_PREFETCH_EN
            r_pf_data  <= '0;
            r_pf_tag   <= RESET_PC;
            r_pf_valid <= 1'b0;
`endif
        end else if (PCClr) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ir_valid <= 1'b0;
            r_mem_read <= 1'b0;
`ifdef IFU_PREFETCH_EN
            r_pf_valid <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef IFU_PREFETCH_EN
                    if (IRLd) begin
                        r_pc <= w_pc_next;
                        if (r_pf_valid && r_pf_tag == r_pc) begin
                            // Buffer hit: load IR now and prefetch the new PC
                            r_ir       <= r_pf_data;
                            r_ir_valid <= 1'b1;
                            r_mem_addr <= w_pc_next;
                            r_pf_tag   <= w_pc_next;
                            r_pf_valid <= 1'b0;
                            r_mem_read <= 1'b1;
                            r_state    <= S_PREFETCH;
                        end else begin
                            r_pf_valid <= 1'b0;
                            r_mem_addr <= r_pc;
                            r_mem_read <= 1'b1;
                            r_ir_valid <= 1'b0;
                            r_state    <= S_WAIT;
                        end
                    end else if (PCUp) begin
                        r_pc       <= r_pc + ADDR_W'(1);
                        r_pf_valid <= 1'b0;
                    end
`else
                    if (IRLd) begin
                        r_mem_addr <= r_pc;
                        r_mem_read <= 1'b1;
                        r_ir_valid <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                    r_pc <= w_pc_next;
`endif
                end
                S_WAIT: begin
                    if (imem.IMemValid) begin
                        r_ir       <= imem.IMemData;
                        r_ir_valid <= 1'b1;
`ifdef IFU_PREFETCH_EN
                        r_mem_addr <= r_pc;
                        r_pf_tag   <= r_pc;
                        r_pf_valid <= 1'b0;
                        r_state    <= S_PREFETCH;
`else
                        r_mem_read <= 1'b0;
                        r_state    <= S_IDLE;
`endif
                    end
                end
`ifdef IFU_PREFETCH_EN
                S_PREFETCH: begin
                    if (IRLd) begin
                        r_pc <= w_pc_next;
                        if (r_pf_tag == r_pc) begin
                            // Request on the read already in flight: behaves as WAIT
                            if (imem.IMemValid) begin
                                r_ir       <= imem.IMemData;
                                r_ir_valid <= 1'b1;
                                r_mem_addr <= w_pc_next;
                                r_pf_tag   <= w_pc_next;
                                r_pf_valid <= 1'b0;
                            end else begin
                                r_ir_valid <= 1'b0;
                                r_state    <= S_WAIT;
                            end
                        end else begin
                            r_pf_valid <= 1'b0;
                            r_mem_addr <= r_pc;
                            r_ir_valid <= 1'b0;
                            r_state    <= S_WAIT;
                        end
                    end else if (PCUp) begin
                        r_pc       <= r_pc + ADDR_W'(1);
                        r_pf_valid <= 1'b0;
                        r_mem_read <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (imem.IMemValid) begin
                        r_pf_data  <= imem.IMemData;
                        r_pf_valid <= 1'b1;
                        r_mem_read <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state    <= S_IDLE;
                    r_mem_read <= 1'b0;
                end
            endcase
        end
    end

    assign imem.IMemAddr = r_mem_addr;
    assign imem.IMemRead = r_mem_read;
    assign Instruction   = r_ir;
    assign PCOut         = r_pc;
    assign IRValid       = r_ir_valid;
    assign FetchStall    = (r_state == S_WAIT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        PCClr = 1'b0;
    logic        PCUp = 1'b0;
    logic        IRLd = 1'b0;
    logic [15:0] Instruction;
    logic [6:0]  PCOut;
    logic        IRValid;
    logic        FetchStall;
    logic [15:0] mem [0:127];
    int          checks = 0;
    int          errors = 0;

    instruction_fetch_unit_if #(.ADDR_W(7)) bus ();

    instruction_fetch_unit #(.ADDR_W(7), .RESET_PC(7'h00)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .PCClr       (PCClr),
        .PCUp        (PCUp),
        .IRLd        (IRLd),
        .imem        (bus.master),
        .Instruction (Instruction),
        .PCOut       (PCOut),
        .IRValid     (IRValid),
        .FetchStall  (FetchStall)
    );

    assign bus.IMemData = mem[bus.IMemAddr];

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        bus.IMemValid = 1'b0;
        #3;
        checks++; if (PCOut !== 7'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", PCOut); end
        checks++; if (Instruction !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h exp 0000", Instruction); end
        checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL reset_irvalid got %b exp 0", IRValid); end
        checks++; if (bus.IMemRead !== 1'b0) begin errors++; $display("FAIL reset_read got %b exp 0", bus.IMemRead); end
        checks++; if (bus.IMemAddr !== 7'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", bus.IMemAddr); end
        checks++; if (FetchStall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", FetchStall); end
        step();
        Rst = 1'b1;
        step();
    endtask

    task automatic test_fetch_basic();
        mem[0] = 16'h2153;
        IRLd = 1'b1; PCUp = 1'b1;
        step();
        IRLd = 1'b0; PCUp = 1'b0;
        checks++; if (bus.IMemAddr !== 7'h00) begin errors++; $display("FAIL basic_addr got %h exp 00", bus.IMemAddr); end
        checks++; if (bus.IMemRead !== 1'b1) begin errors++; $display("FAIL basic_read got %b exp 1", bus.IMemRead); end
        checks++; if (FetchStall !== 1'b1) begin errors++; $display("FAIL basic_stall got %b exp 1", FetchStall); end
        checks++; if (PCOut !== 7'h01) begin errors++; $display("FAIL basic_pc got %h exp 01", PCOut); end
        bus.IMemValid = 1'b1;
        step();
        bus.IMemValid = 1'b0;
        checks++; if (Instruction !== 16'h2153) begin errors++; $display("FAIL basic_ir got %h exp 2153", Instruction); end
        checks++; if (IRValid !== 1'b1) begin errors++; $display("FAIL basic_irvalid got %b exp 1", IRValid); end
        checks++; if (FetchStall !== 1'b0) begin errors++; $display("FAIL basic_stall_end got %b exp 0", FetchStall); end
        checks++; if (bus.IMemRead !== 1'b0) begin errors++; $display("FAIL basic_read_end got %b exp 0", bus.IMemRead); end
    endtask

    task automatic test_delayed_valid();
        int stall_cycles = 0;
        mem[1] = 16'hA5C3;
        IRLd = 1'b1;
        step();
        if (FetchStall) stall_cycles++;
        checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL delay_irvalid got %b exp 0", IRValid); end
        PCUp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (FetchStall) stall_cycles++;
        end
        checks++; if (PCOut !== 7'h01) begin errors++; $display("FAIL delay_pc_hold got %h exp 01", PCOut); end
        checks++; if (bus.IMemAddr !== 7'h01) begin errors++; $display("FAIL delay_addr got %h exp 01", bus.IMemAddr); end
        IRLd = 1'b0; PCUp = 1'b0;
        bus.IMemValid = 1'b1;
        step();
        bus.IMemValid = 1'b0;
        checks++; if (stall_cycles !== 4) begin errors++; $display("FAIL delay_stall_cycles got %0d exp 4", stall_cycles); end
        checks++; if (FetchStall !== 1'b0) begin errors++; $display("FAIL delay_stall_end got %b exp 0", FetchStall); end
        checks++; if (Instruction !== 16'hA5C3) begin errors++; $display("FAIL delay_ir got %h exp a5c3", Instruction); end
        checks++; if (IRValid !== 1'b1) begin errors++; $display("FAIL delay_irvalid_end got %b exp 1", IRValid); end
    endtask

    task automatic test_wrap();
        PCUp = 1'b1;
        for (int i = 0; i < 126; i++) step();
        PCUp = 1'b0;
        checks++; if (PCOut !== 7'h7F) begin errors++; $display("FAIL wrap_pre got %h exp 7f", PCOut); end
        PCUp = 1'b1;
        step();
        PCUp = 1'b0;
        checks++; if (PCOut !== 7'h00) begin errors++; $display("FAIL wrap_pc got %h exp 00", PCOut); end
        mem[0] = 16'h3C0F;
        IRLd = 1'b1;
        step();
        IRLd = 1'b0;
        checks++; if (bus.IMemAddr !== 7'h00) begin errors++; $display("FAIL wrap_addr got %h exp 00", bus.IMemAddr); end
        bus.IMemValid = 1'b1;
        step();
        bus.IMemValid = 1'b0;
        checks++; if (Instruction !== 16'h3C0F) begin errors++; $display("FAIL wrap_ir got %h exp 3c0f", Instruction); end
    endtask

    task automatic test_pcclr_wait();
        mem[2] = 16'h1234;
        PCUp = 1'b1;
        step(); step();
        PCUp = 1'b0;
        IRLd = 1'b1;
        step();
        IRLd = 1'b0;
        checks++; if (bus.IMemAddr !== 7'h02) begin errors++; $display("FAIL clr_addr got %h exp 02", bus.IMemAddr); end
        PCClr = 1'b1; IRLd = 1'b1; PCUp = 1'b1;
        step();
        PCClr = 1'b0; IRLd = 1'b0; PCUp = 1'b0;
        checks++; if (bus.IMemRead !== 1'b0) begin errors++; $display("FAIL clr_read got %b exp 0", bus.IMemRead); end
        bus.IMemValid = 1'b1;
        step();
        bus.IMemValid = 1'b0;
        checks++; if (PCOut !== 7'h00) begin errors++; $display("FAIL clr_pc got %h exp 00", PCOut); end
        checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL clr_irvalid got %b exp 0", IRValid); end
        checks++; if (Instruction !== 16'h3C0F) begin errors++; $display("FAIL clr_ir_kept got %h exp 3c0f", Instruction); end
        checks++; if (FetchStall !== 1'b0) begin errors++; $display("FAIL clr_stall got %b exp 0", FetchStall); end
    endtask

    task automatic test_reset_midfetch();
        IRLd = 1'b1; PCUp = 1'b1;
        step();
        IRLd = 1'b0; PCUp = 1'b0;
        checks++; if (FetchStall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %b exp 1", FetchStall); end
        #2;
        Rst = 1'b0;
        #1;
        checks++; if (PCOut !== 7'h00) begin errors++; $display("FAIL rst_mid_pc got %h exp 00", PCOut); end
        checks++; if (Instruction !== 16'h0000) begin errors++; $display("FAIL rst_mid_ir got %h exp 0000", Instruction); end
        checks++; if (bus.IMemRead !== 1'b0) begin errors++; $display("FAIL rst_mid_read got %b exp 0", bus.IMemRead); end
        checks++; if (FetchStall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b exp 0", FetchStall); end
        bus.IMemValid = 1'b1;
        step();
        bus.IMemValid = 1'b0;
        checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL rst_mid_irvalid got %b exp 0", IRValid); end
        Rst = 1'b1;
        step();
    endtask

`ifdef IFU_PREFETCH_EN
    task automatic test_prefetch();
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        bus.IMemValid = 1'b1;
        IRLd = 1'b1; PCUp = 1'b1;
        step();
        IRLd = 1'b0; PCUp = 1'b0;
        step(); step();
        checks++; if (Instruction !== 16'h1111) begin errors++; $display("FAIL pf_ir0 got %h exp 1111", Instruction); end
        IRLd = 1'b1; PCUp = 1'b1;
        step();
        IRLd = 1'b0; PCUp = 1'b0;
        checks++; if (Instruction !== 16'h2222) begin errors++; $display("FAIL pf_ir1 got %h exp 2222", Instruction); end
        checks++; if (FetchStall !== 1'b0) begin errors++; $display("FAIL pf_stall1 got %b exp 0", FetchStall); end
        step();
        IRLd = 1'b1; PCUp = 1'b1;
        step();
        IRLd = 1'b0; PCUp = 1'b0;
        checks++; if (Instruction !== 16'h3333) begin errors++; $display("FAIL pf_ir2 got %h exp 3333", Instruction); end
        checks++; if (FetchStall !== 1'b0) begin errors++; $display("FAIL pf_stall2 got %b exp 0", FetchStall); end
        bus.IMemValid = 1'b0;
        PCClr = 1'b1;
        step();
        PCClr = 1'b0;
        IRLd = 1'b1;
        step();
        IRLd = 1'b0;
        checks++; if (FetchStall !== 1'b1) begin errors++; $display("FAIL pf_clr_stall got %b exp 1", FetchStall); end
        bus.IMemValid = 1'b1;
        step();
        bus.IMemValid = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'(i);
        bus.IMemValid = 1'b0;
        test_reset();
`ifdef IFU_PREFETCH_EN
        test_prefetch();
`else
        test_fetch_basic();
        test_delayed_valid();
        test_wrap();
        test_pcclr_wait();
        test_reset_midfetch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
